// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute-stage multiply/divide sequencer.
//   muldiv_op_t    : decoded multiply/divide operation codes (op class 3'b100)
//   muldiv_state_t : sequencer FSM states
//   OPCLASS_MULDIV : decode op class that routes an instruction to the sequencer
//   abs32()        : two's complement magnitude of a 32-bit value
package cpu_pkg;

  localparam logic [2:0] OPCLASS_MULDIV = 3'b100;

  typedef enum logic [2:0] {
    MUL  = 3'b000,
    DIVS = 3'b100,
    MODS = 3'b101,
    DIVU = 3'b110,
    MODU = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } muldiv_state_t;

  // |v|; the most negative value maps to itself, which is the correct
  // unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/cpu_div_step.sv
// One radix-2 restoring division step (purely combinational).
//   rem       in  current partial remainder
//   quo       in  quotient register; its upper bits still hold unconsumed dividend
//   divisor   in  divisor magnitude
//   rem_next  out partial remainder after this step
//   quo_next  out quotient register shifted left with the new quotient bit
module cpu_div_step
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          take;

  always_comb begin
    // Bring down the next dividend bit from the top of the quotient register.
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    take     = ~diff[XLEN];
    rem_next = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], take};
  end

endmodule

// File: rtl/cpu_muldiv_seq.sv
// Execute-stage multiply/divide sequencer.
// Accepts one mul/div op, stalls the pipeline while iterating, then pulses
// done with the 32-bit result (low product, quotient or remainder).
// Build option: define CPU_FAST_MUL_EN for a single-cycle multiply; otherwise
// multiply is a 32-iteration shift-add sharing the divide datapath registers.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   start         op valid this cycle
//   op            000 mul, 100 divs, 101 mods, 110 divu, 111 modu
//   src_a, src_b  dividend/multiplicand, divisor/multiplier
//   kill          pipeline flush; aborts any op, start ignored
//   stall         hold pipeline (combinational)
//   done          one-cycle result-valid pulse (registered)
//   result        result, held until the next completion (registered)
module cpu_muldiv_seq
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_t   state_q, state_d;
  logic [4:0]      count_q, count_d;
  // a_q: dividend shifting into quotient (div) or multiplicand (mul)
  // b_q: divisor magnitude (div) or multiplier (mul)
  // rem_q: partial remainder (div) or product accumulator (mul)
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            is_mul_q, is_mul_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Input op decode
  logic            legal;
  logic            dec_mul;
  logic            dec_rem;
  logic            dec_signed;
  logic            fast_mul;
  logic            short_path;
  logic [XLEN-1:0] short_val;

  // Iteration datapath
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] final_val;

  cpu_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem     (rem_q),
    .quo     (a_q),
    .divisor (b_q),
    .rem_next(step_rem),
    .quo_next(step_quo)
  );

  always_comb begin
    legal      = 1'b1;
    dec_mul    = 1'b0;
    dec_rem    = 1'b0;
    dec_signed = 1'b0;
    case (op)
      MUL:     dec_mul = 1'b1;
      DIVS:    dec_signed = 1'b1;
      MODS: begin
        dec_signed = 1'b1;
        dec_rem    = 1'b1;
      end
      DIVU:    ;
      MODU:    dec_rem = 1'b1;
      default: legal = 1'b0;
    endcase
  end

`ifdef CPU_FAST_MUL_EN
  logic [XLEN-1:0] fast_prod;
  assign fast_prod = src_a * src_b;
  assign fast_mul  = legal & dec_mul;
`else
  assign fast_mul  = 1'b0;
`endif

  always_comb begin
    short_path = ~legal | fast_mul | (legal & ~dec_mul & (src_b == '0));
    if (!legal) begin
      short_val = '0;
    end else if (dec_mul) begin
`ifdef CPU_FAST_MUL_EN
      short_val = fast_prod;
`else
      short_val = '0;  // not reachable: iterative mul never takes the short path
`endif
    end else begin
      // Divide by zero: all-ones quotient, remainder is the raw dividend.
      short_val = dec_rem ? src_a : '1;
    end
  end

  always_comb begin
    mul_acc = rem_q + (b_q[0] ? a_q : '0);
    if (is_mul_q) begin
      final_val = mul_acc;
    end else if (is_rem_q) begin
      final_val = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
    end else begin
      final_val = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    is_mul_d  = is_mul_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          count_d   = 5'd31;
          rem_d     = '0;
          is_mul_d  = dec_mul;
          is_rem_d  = dec_rem;
          neg_quo_d = dec_signed & (src_a[XLEN-1] ^ src_b[XLEN-1]);
          neg_rem_d = dec_signed & src_a[XLEN-1];
          a_d       = dec_signed ? abs32(src_a) : src_a;
          b_d       = dec_signed ? abs32(src_b) : src_b;
          if (short_path) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = short_val;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (is_mul_q) begin
            rem_d = mul_acc;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else begin
            rem_d = step_rem;
            a_d   = step_quo;
          end
          if (count_q == '0) begin
            state_d  = FIN;
            done_d   = 1'b1;
            result_d = final_val;
          end else begin
            count_d = count_q - 5'd1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      is_mul_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      is_mul_q  <= is_mul_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign stall  = ((state_q == IDLE) && start && !kill) || (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_cpu_muldiv_seq.sv
// Self-checking bench for cpu_muldiv_seq: directed ops push expected result
// and completion cycle into a scoreboard; a monitor checks every done pulse.
module tb_cpu_muldiv_seq;

`ifdef CPU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        kill;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  string       name_q[$];

  cpu_muldiv_seq #(
    .XLEN(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .kill  (kill),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h at cycle %0d, required no done", result,
                 cyc);
      end else begin
        logic [31:0] er;
        int          ec;
        string       nm;
        er = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (result !== er) begin
          errors++;
          $display("FAIL %s_result: got %h required %h", nm, result, er);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL %s_latency: done at cycle %0d required %0d", nm, cyc, ec);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Issue one op and wait (bounded) for its completion; stall must be high
  // for exactly lat cycles starting with the issue cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int lat, input string nm);
    int stalls;
    int waited;
    @(negedge clock);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    exp_q.push_back(exp_r);
    exp_cyc_q.push_back(cyc + lat);
    name_q.push_back(nm);
    stalls = 0;
    #1;
    if (stall) stalls++;
    for (waited = 0; waited < 50; waited++) begin
      @(negedge clock);
      start = 1'b0;
      #1;
      if (stall) stalls++;
      if (exp_q.size() == 0) break;
    end
    if (waited == 50) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within 50 cycles, required done at +%0d", nm, lat);
      exp_q.delete();
      exp_cyc_q.delete();
      name_q.delete();
    end
    check({nm, "_stall_cycles"}, stalls, lat);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'b000;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clock);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op(3'b110, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, "modu_100_7");
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, "divs_m100_7");
    run_op(3'b101, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, "mods_m100_7");
    run_op(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "divs_100_m7");
    run_op(3'b101, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, "mods_100_m7");
    run_op(3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
    run_op(3'b110, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
    run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, "modu_5_0");
    run_op(3'b101, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "mods_m5_0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "divs_ovf");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "mods_ovf");
    run_op(3'b000, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, MulLat, "mul_small");
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MulLat, "mul_neg1_sq");
    run_op(3'b010, 32'd9, 32'd3, 32'd0, 1, "illegal_010");
    run_op(3'b110, 32'd100, 32'd7, 32'd14, 33, "divu_before_kill");

    // Kill mid-RUN: no done, result retained, stall low immediately after.
    @(negedge clock);
    start = 1'b1;
    op    = 3'b110;
    src_a = 32'd1000;
    src_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    #1;
    check("kill_stall", {31'd0, stall}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clock);
    check("kill_result_kept", result, 32'd14);

    // kill together with start is ignored entirely.
    @(negedge clock);
    start = 1'b1;
    kill  = 1'b1;
    op    = 3'b110;
    src_a = 32'd50;
    src_b = 32'd5;
    #1;
    check("kill_start_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    start = 1'b0;
    kill  = 1'b0;
    #1;
    check("kill_start_idle", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clock);

    run_op(3'b111, 32'd50, 32'd6, 32'd2, 33, "modu_after_kill");

    // Reset mid-RUN: no done pulse, result cleared.
    @(negedge clock);
    start = 1'b1;
    op    = 3'b110;
    src_a = 32'd77;
    src_b = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clock);
    check("rst_mid_result_later", result, 32'd0);

    run_op(3'b110, 32'd77, 32'd4, 32'd19, 33, "divu_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
